// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset controller.
// Synchronizes and debounces the active-low POR from the supervisor, then releases the
// active-low stage resets one at a time, STAGE_GAP cycles apart, and raises READY_O one gap
// after the last stage. A level software request holds all stages in reset for at least
// HOLD_CYCLES and replays the staged release once it is dropped.
//
// Ports:
//   CLK           rising-edge clock
//   RST           synchronous active-high reset
//   POR_N_I       asynchronous active-low power-on reset from the supervisor
//   SW_RST_REQ_I  software reset request (level)
//   SW_RST_ACK_O  software reset acknowledge (level, registered)
//   RST_N_O       sequenced active-low resets, bit 0 released first (registered)
//   READY_O       all stages released and sequencer running (registered)
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  POR_N_I,
  input  logic                  SW_RST_REQ_I,
  output logic                  SW_RST_ACK_O,
  output logic [NUM_STAGES-1:0] RST_N_O,
  output logic                  READY_O
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CntW-1:0]       HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]       GapLoad  = CntW'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] FirstRel = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    StWaitPor,
    StHold,
    StRelease,
    StRun,
    StSwAssert
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0]   rst_n_q, rst_n_d;
  logic                    ready_q, ready_d;
  logic                    ack_q, ack_d;
  logic                    por_s;

  // Only this shift register samples the asynchronous POR input.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], POR_N_I};
  assign por_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    ack_d   = ack_q;

    // Losing POR outranks every other transition.
    if (!por_s && (state_q != StWaitPor)) begin
      state_d = StWaitPor;
      rst_n_d = '0;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        StWaitPor: begin
          rst_n_d = '0;
          ready_d = 1'b0;
          ack_d   = 1'b0;
          if (por_s) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_d = StRelease;
            rst_n_d = FirstRel;
            idx_d   = '0;
            cnt_d   = GapLoad;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StRelease: begin
          if (cnt_q == '0) begin
            if (idx_q < LastIdx) begin
              // Released bits form a thermometer code, so the next stage is a shift-in.
              rst_n_d = (rst_n_q << 1) | FirstRel;
              idx_d   = idx_q + IdxW'(1);
              cnt_d   = GapLoad;
            end else begin
              state_d = StRun;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StRun: begin
          if (SW_RST_REQ_I) begin
            state_d = StSwAssert;
            rst_n_d = '0;
            ready_d = 1'b0;
            ack_d   = 1'b1;
            cnt_d   = HoldLoad;
          end
        end
        StSwAssert: begin
          // Counter saturates at 0 so a long request simply keeps the hold going.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else if (!SW_RST_REQ_I) begin
            state_d = StRelease;
            ack_d   = 1'b0;
            rst_n_d = FirstRel;
            idx_d   = '0;
            cnt_d   = GapLoad;
          end
        end
        default: begin
          state_d = StWaitPor;
          rst_n_d = '0;
          ready_d = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StWaitPor;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign RST_N_O      = rst_n_q;
  assign READY_O      = ready_q;
  assign SW_RST_ACK_O = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by randomized POR drops, software
// requests and resets. A reference model turns each sampled edge into expected outputs
// (release times computed arithmetically from the last POR loss or software release) and
// queues them; a monitor on the falling edge pops and compares.
module tb_reset_sequencer;

  localparam int N        = 3;
  localparam int HOLD     = 16;
  localparam int GAP      = 4;
  localparam int SYNC     = 2;
  localparam int MaxEdges = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic         por_n;
  logic         sw_req;
  logic         ack;
  logic [N-1:0] rst_n;
  logic         ready;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES  (N),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .POR_N_I      (por_n),
    .SW_RST_REQ_I (sw_req),
    .SW_RST_ACK_O (ack),
    .RST_N_O      (rst_n),
    .READY_O      (ready)
  );

  int edge_cnt = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  bit por_hist [MaxEdges];
  bit rst_hist [MaxEdges];

  logic [N+1:0] exp_q [$];

  // Model state: edge at which stage 0 releases, or the edge a software hold began.
  int m_base   = 1 << 30;
  bit m_sw     = 1'b0;
  int m_sw_beg = 0;

  int           mk;
  bit           m_ps;
  bit           m_was_run;
  logic [N-1:0] m_rst_n;
  logic         m_ready;
  logic         m_ack;

  always @(posedge clk) begin
    mk = edge_cnt;
    if (mk < MaxEdges) begin
      por_hist[mk] = por_n;
      rst_hist[mk] = rst;
    end
    // POR as seen by the FSM: input delayed SYNC edges, cleared by any reset in that window.
    m_ps = (mk >= SYNC) && (mk < MaxEdges) && por_hist[mk-SYNC];
    for (int j = mk - SYNC; j < mk; j++) begin
      if (j >= 0 && j < MaxEdges && rst_hist[j]) m_ps = 1'b0;
    end
    m_was_run = !m_sw && (mk - 1 >= m_base + N * GAP);

    if (rst || !m_ps) begin
      m_sw   = 1'b0;
      m_base = mk + 1 + HOLD;
    end else if (m_was_run && sw_req) begin
      m_sw     = 1'b1;
      m_sw_beg = mk;
    end else if (m_sw && (mk >= m_sw_beg + HOLD) && !sw_req) begin
      m_sw   = 1'b0;
      m_base = mk;
    end

    if (m_sw) begin
      m_rst_n = '0;
      m_ready = 1'b0;
      m_ack   = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) m_rst_n[i] = (mk >= m_base + i * GAP);
      m_ready = (mk >= m_base + N * GAP);
      m_ack   = 1'b0;
    end
    exp_q.push_back({m_rst_n, m_ready, m_ack});
    edge_cnt = edge_cnt + 1;
  end

  logic [N+1:0] mon_exp;
  logic [N+1:0] mon_got;

  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      n_cmp = n_cmp + 1;
      mon_got = {rst_n, ready, ack};
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_empty edge %0d got %b", edge_cnt - 1, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail = n_fail + 1;
          $display("FAIL outputs after edge %0d {rst_n,ready,ack}: got %b expected %b",
                   edge_cnt - 1, mon_got, mon_exp);
        end
      end
    end
  end

  task automatic at_edge(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_edges(input int n);
    at_edge(edge_cnt + n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  bit found;
  int sel;
  int len;

  initial begin
    rst    = 1'b1;
    por_n  = 1'b0;
    sw_req = 1'b0;

    // Cold start.
    at_edge(3);   rst   = 1'b0;
    at_edge(10);  por_n = 1'b1;
    // POR loss in RUN, then a short glitch before POR settles.
    at_edge(100); por_n = 1'b0;
    at_edge(103); por_n = 1'b1;
    at_edge(108); por_n = 1'b0;
    at_edge(111); por_n = 1'b1;
    // Software reset shorter than the hold time.
    at_edge(200); sw_req = 1'b1;
    at_edge(203); sw_req = 1'b0;
    // Software reset pre-empted by POR loss; request lingers past the POR drop.
    at_edge(300); sw_req = 1'b1;
    at_edge(305); por_n  = 1'b0;
    at_edge(308); por_n  = 1'b1;
    at_edge(320); sw_req = 1'b0;
    // Reset asserted while only stage 0 is released.
    at_edge(400); por_n  = 1'b0;
    at_edge(402); por_n  = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (rst_n === 3'b001) found = 1'b1;
    end
    n_cmp = n_cmp + 1;
    if (!found) begin
      n_fail = n_fail + 1;
      $display("FAIL wait_stage0_only: rst_n is %b, required 001 within 100 cycles", rst_n);
    end
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    wait_edges(60);

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        wait_edges($urandom_range(40, 90));
      end else if (sel <= 6) begin
        sw_req = 1'b1;
        wait_edges($urandom_range(1, 30));
        sw_req = 1'b0;
        wait_edges($urandom_range(1, 10));
      end else if (sel == 7) begin
        por_n = 1'b0;
        wait_edges($urandom_range(1, 5));
        por_n = 1'b1;
        wait_edges($urandom_range(1, 20));
      end else if (sel == 8) begin
        rst = 1'b1;
        wait_edges($urandom_range(1, 3));
        rst = 1'b0;
        wait_edges($urandom_range(1, 20));
      end else begin
        sw_req = 1'b1;
        len = $urandom_range(2, 12);
        wait_edges(len);
        por_n = 1'b0;
        wait_edges($urandom_range(1, 4));
        por_n = 1'b1;
        wait_edges($urandom_range(1, 30));
        sw_req = 1'b0;
      end
    end
    wait_edges(80);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller that consumes the asynchronous, active-low output of the DS9809 power-on-reset supervisor, debounces it, and releases a set of active-low reset outputs one at a time with a fixed gap between stages. It also serves a software reset request with a four-phase handshake. It sits between the POR_DS9809PRSS3 cell and the reset inputs of the board's logic partitions.

## Interface
- NUM_STAGES, 3, number of sequenced reset outputs (≥1)
- HOLD_CYCLES, 16, cycles the synchronized POR must stay high before the first release; also the minimum software-reset assertion (≥1)
- STAGE_GAP, 4, cycles between consecutive stage releases and from the last stage to READY_O (≥1)
- SYNC_STAGES, 2, flops in the POR_N_I synchronizer (≥2)

- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset; one clock, synchronous active-high reset is fixed for this block
- POR_N_I  in  1  asynchronous active-low POR from the DS9809 (its RESET_N)
- SW_RST_REQ_I  in  1  software reset request (level)
- SW_RST_ACK_O  out  1  software reset acknowledge (level)
- RST_N_O  out  NUM_STAGES  sequenced active-low resets; bit 0 releases first
- READY_O  out  1  all stages released, sequencer in RUN

## Operation
- POR_N_I passes through a SYNC_STAGES-flop synchronizer (reset to 0) giving por_s. Nothing else samples POR_N_I.
- One down-counter, wide enough for max(HOLD_CYCLES, STAGE_GAP). One stage index, $clog2(NUM_STAGES) bits, minimum 1.
- All outputs are registered. Reset values: RST_N_O = all 0, READY_O = 0, SW_RST_ACK_O = 0, state WAIT_POR, synchronizer 0.
- States and transitions:
  - WAIT_POR: outputs all 0. If por_s=1, go to HOLD and load the counter with HOLD_CYCLES-1.
  - HOLD: if por_s=0, go to WAIT_POR (debounce restart). Otherwise, when the counter reaches 0, set RST_N_O[0]=1, index=0, load STAGE_GAP-1, and go to RELEASE. Otherwise decrement.
  - RELEASE: when the counter reaches 0:
    - if index < NUM_STAGES-1, set RST_N_O[index+1]=1, increment the index, and reload;
    - else set READY_O=1 and go to RUN.
    - Released bits stay 1.
  - RUN: READY_O=1 and all RST_N_O=1. If SW_RST_REQ_I=1, go to SW_ASSERT: RST_N_O=0, READY_O=0, SW_RST_ACK_O=1, load HOLD_CYCLES-1.
  - SW_ASSERT: hold all resets. Decrement to 0 and saturate. When the counter is 0 and SW_RST_REQ_I=0: ACK=0, RST_N_O[0]=1, index=0, load STAGE_GAP-1, go to RELEASE (no re-debounce).
- por_s=0 in any state other than WAIT_POR:
  - next edge: RST_N_O=0, READY_O=0, ACK=0, state WAIT_POR;
  - takes priority over every other transition.
- SW_RST_REQ_I is ignored outside RUN and SW_ASSERT. A request still high on entering RUN is taken on the next edge.
- RST=1 at any edge returns everything to reset values, mid-sequence included.

## Timing
- Let e be the first edge at which POR_N_I is sampled high. por_s=1 is visible after edge e+SYNC_STAGES-1, and HOLD is entered at edge e+SYNC_STAGES.
- Let h = e+SYNC_STAGES+HOLD_CYCLES. Then:
  - RST_N_O[i] rises at edge h + i·STAGE_GAP;
  - READY_O rises at edge h + NUM_STAGES·STAGE_GAP.
- POR loss: POR_N_I sampled low at edge t → all outputs 0 after edge t+SYNC_STAGES.
- SW reset:
  - request sampled at edge r in RUN → resets asserted and ACK=1 after edge r+1;
  - resets held at least HOLD_CYCLES cycles;
  - with REQ low at edge d (d ≥ r+1+HOLD_CYCLES-1), ACK falls and RST_N_O[0] rises after edge d+1;
  - later stages follow at STAGE_GAP spacing.
- Outputs change only on CLK rising edges. No combinational input-to-output path.

## Test plan
- Cold start (defaults): RST high for 3 cycles, POR_N_I high from edge 10 → RST_N_O[0]/[1]/[2] rise at edges 28/32/36, READY_O at 40; no bit falls afterwards.
- POR glitch: POR_N_I high for 5 cycles, then low for 3, then high from edge 30 → no RST_N_O bit rises before edge 48; the full sequence completes at 48/52/56 with READY at 60.
- POR loss in RUN: POR_N_I low sampled at edge 100 → RST_N_O=000, READY=0 after edge 102; re-release follows the cold-start timing.
- SW reset: REQ high at edge 200 for 3 cycles → ACK=1 and RST_N_O=000 after 201; REQ low but hold not elapsed, so ACK stays 1 until edge 217; stages release at 217/221/225, READY at 229.
- SW reset pre-empted by POR: POR_N_I drops during SW_ASSERT → ACK=0 and state WAIT_POR 2 edges later; resets stay 0 until the POR sequence completes.
- RST mid-RELEASE: RST high while RST_N_O=001 → all outputs 0 next edge; the sequence restarts from WAIT_POR after RST falls.
